// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// streams, appends parity, paces frames on tx_busy and keeps packets contiguous.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int BUSY_WAIT  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            tx_enable,
  output logic [DATA_WIDTH+PARITY_EN-1:0] tx_data,
  input  logic                            tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            active,
  output logic                            err_stall
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TX_W  = DATA_WIDTH + PARITY_EN;
  localparam int CNT_W = $clog2(BUSY_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    NEXT      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              lock_q, lock_d;
  logic              active_q, active_d;
  logic              err_stall_q, err_stall_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TX_W-1:0]   tx_data_q, tx_data_d;

  logic                  rr_found;
  logic [ID_W-1:0]       rr_idx;
  logic [ID_W-1:0]       scan_idx;
  logic [ID_W-1:0]       sel_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic [TX_W-1:0]       frame;
  logic                  accept;
  logic [ID_W-1:0]       next_ptr;

  // First valid requester at or after the pointer, scanning modulo NUM_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    scan_idx = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!rr_found && req_valid[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end

  assign sel_idx  = (state_q == NEXT) ? grant_id_q : rr_idx;
  assign sel_data = req_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last = req_last[sel_idx];
  assign next_ptr = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  generate
    if (PARITY_EN != 0) begin : g_parity
      assign frame = {(^sel_data) ^ (PARITY_ODD != 0), sel_data};
    end else begin : g_no_parity
      assign frame = sel_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      lock_q      <= 1'b0;
      active_q    <= 1'b0;
      err_stall_q <= 1'b0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      lock_q      <= lock_d;
      active_q    <= active_d;
      err_stall_q <= err_stall_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    lock_d      = lock_q;
    active_d    = active_q;
    err_stall_d = err_stall_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_id_d = sel_idx;
          active_d   = 1'b1;
          lock_d     = !sel_last;
          tx_data_d  = frame;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_WAIT - 1)) begin
          // Transmitter never acknowledged: drop the packet and move on.
          err_stall_d = 1'b1;
          lock_d      = 1'b0;
          active_d    = 1'b0;
          ptr_d       = next_ptr;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (lock_q) begin
            state_d = NEXT;
          end else begin
            active_d = 1'b0;
            ptr_d    = next_ptr;
            state_d  = IDLE;
          end
        end
      end
      NEXT: begin
        if (accept) begin
          lock_d    = !sel_last;
          tx_data_d = frame;
          state_d   = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    tx_enable = 1'b0;
    req_ready = '0;
    if (!reset) begin
      case (state_q)
        IDLE:    accept    = rr_found;
        NEXT:    accept    = req_valid[grant_id_q];
        LOAD:    tx_enable = 1'b1;
        default: accept    = 1'b0;
      endcase
    end
    if (accept) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign active    = active_q;
  assign err_stall = err_stall_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed multi-cycle sequences and a
// randomized phase checked against a queue-based arbitration model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BW = 4;
  localparam int NPKT = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            tx_busy = 1'b0;

  logic [N-1:0] rdy_e, rdy_o, rdy_n;
  logic         en_e, en_o, en_n;
  logic [8:0]   data_e, data_o;
  logic [7:0]   data_n;
  logic [1:0]   gid_e, gid_o, gid_n;
  logic         act_e, act_o, act_n;
  logic         err_e, err_o, err_n;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .PARITY_EN(1), .PARITY_ODD(0), .BUSY_WAIT(BW)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(rdy_e), .tx_enable(en_e), .tx_data(data_e), .tx_busy(tx_busy),
    .grant_id(gid_e), .active(act_e), .err_stall(err_e));

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .PARITY_EN(1), .PARITY_ODD(1), .BUSY_WAIT(BW)) u_odd (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(rdy_o), .tx_enable(en_o), .tx_data(data_o), .tx_busy(tx_busy),
    .grant_id(gid_o), .active(act_o), .err_stall(err_o));

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .PARITY_EN(0), .PARITY_ODD(0), .BUSY_WAIT(BW)) u_nop (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(rdy_n), .tx_enable(en_n), .tx_data(data_n), .tx_busy(tx_busy),
    .grant_id(gid_n), .active(act_n), .err_stall(err_n));

  // Transmitter: samples the load strobe, raises busy two edges later, stays busy a random 2..6 cycles.
  logic tie_low = 1'b0;
  int   dly = 0;
  int   fcnt = 0;
  always @(posedge clk) begin
    if (reset) begin
      tx_busy <= 1'b0;
      dly     <= 0;
      fcnt    <= 0;
    end else begin
      if (en_e) dly <= 2;
      else if (dly > 0) dly <= dly - 1;
      if (dly == 1 && !tie_low) begin
        tx_busy <= 1'b1;
        fcnt    <= $urandom_range(2, 6);
      end else if (tx_busy) begin
        if (fcnt <= 1) tx_busy <= 1'b0;
        else fcnt <= fcnt - 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  logic exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  function automatic logic [8:0] even_frame(input logic [7:0] d);
    return {^d, d};
  endfunction

  typedef struct {
    logic [N-1:0] mask;
    logic [7:0]   base;
    int           gid;
    logic [8:0]   frame;
  } vec_t;
  vec_t vecs[8];

  // Offers base+i on every requester in mask (last=1) and checks the single resulting frame.
  task automatic send_vec(input logic [N-1:0] mask, input logic [7:0] base, input int gid,
                          input logic [8:0] exp_frame);
    int n;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base + 8'(i);
    req_last  = '1;
    req_valid = mask;
    n = 0;
    do begin @(negedge clk); n++; end while (rdy_e == '0 && n < 200);
    chk("vec_ready", rdy_e, oh(gid));
    chk("vec_ready_odd", rdy_o, oh(gid));
    chk("vec_ready_nopar", rdy_n, oh(gid));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("vec_tx_enable", {en_e, en_o, en_n}, 3'b111);
    chk("vec_tx_data", data_e, exp_frame);
    chk("vec_tx_data_odd", data_o, exp_frame ^ 9'h100);
    chk("vec_tx_data_nopar", data_n, exp_frame[7:0]);
    chk("vec_grant_id", {gid_e, gid_o, gid_n}, {3{2'(gid)}});
    chk("vec_active", act_e, 1);
    @(negedge clk);
    chk("vec_enable_one_cycle", en_e, 0);
    n = 0;
    while (act_e && n < 200) begin @(negedge clk); n++; end
    chk("vec_active_drop", {act_e, act_o, act_n}, 0);
    chk("vec_err_stall", {err_e, err_o, err_n}, {3{exp_err}});
  endtask

  int n, m, w, ptr_m, cur_m, pkts, tot_bytes, frames_seen;
  logic locked_m, seen;
  logic [N-1:0] acc;
  logic [7:0] b;
  logic [8:0] f;
  logic [8:0] expq[$];
  int rem[N];

  initial begin
    vecs[0] = '{4'b0001, 8'hA5, 0, 9'h0A5};
    vecs[1] = '{4'b0001, 8'h07, 0, 9'h107};
    vecs[2] = '{4'b1010, 8'h10, 1, 9'h011};
    vecs[3] = '{4'b1011, 8'h20, 3, 9'h123};
    vecs[4] = '{4'b1110, 8'h30, 1, 9'h131};
    vecs[5] = '{4'b0101, 8'hFF, 2, 9'h101};
    vecs[6] = '{4'b1111, 8'h7E, 3, 9'h081};
    vecs[7] = '{4'b1000, 8'h00, 3, 9'h003};

    // Reset: requests present but nothing may be granted.
    repeat (2) @(posedge clk);
    #1 req_valid = '1; req_last = '1;
    @(negedge clk);
    chk("reset_outputs", {rdy_e, en_e, data_e, gid_e, act_e, err_e}, 0);
    chk("reset_outputs_odd", {rdy_o, en_o, data_o, gid_o, act_o, err_o}, 0);
    chk("reset_outputs_nopar", {rdy_n, en_n, data_n, gid_n, act_n, err_n}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;

    for (int v = 0; v < 8; v++) send_vec(vecs[v].mask, vecs[v].base, vecs[v].gid, vecs[v].frame);

    // Packet lock: requester 1 sends three bytes while requester 2 waits.
    @(posedge clk); #1;
    req_data[DW +: DW] = 8'hC0;
    req_data[2*DW +: DW] = 8'h55;
    req_last = 4'b0100;
    req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (rdy_e == '0 && n < 200);
      chk("lock_ready", rdy_e, 4'b0010);
      if (k > 0) chk("lock_active_held", act_e, 1);
      b = 8'hC0 + 8'(k);
      @(posedge clk); #1;
      req_data[DW +: DW] = 8'hC0 + 8'(k + 1);
      req_last[1] = (k == 1);
      @(negedge clk);
      chk("lock_tx_data", data_e, even_frame(b));
      chk("lock_grant_id", gid_e, 1);
    end
    req_valid = 4'b0100;
    n = 0;
    do begin @(negedge clk); n++; end while (rdy_e == '0 && n < 200);
    chk("lock_then_other", rdy_e, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("lock_other_data", data_e, 9'h055);
    chk("lock_other_gid", gid_e, 2);
    n = 0;
    while (act_e && n < 200) begin @(negedge clk); n++; end
    chk("lock_done", act_e, 0);

    // Stall: busy never rises.
    tie_low = 1'b1;
    @(posedge clk); #1;
    req_data[0 +: DW] = 8'h3C;
    req_last = '1;
    req_valid = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (rdy_e == '0 && n < 200);
    chk("stall_ready", rdy_e, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    m = 0;
    do begin @(posedge clk); #1; m++; end while (!err_e && m < 50);
    chk("stall_cycles", m, 1 + BW);
    chk("stall_active", act_e, 0);
    tie_low = 1'b0;
    exp_err = 1'b1;
    send_vec(4'b0100, 8'h60, 2, 9'h162);

    // Reset during WAIT_DONE of a locked packet.
    @(posedge clk); #1;
    req_data[0 +: DW] = 8'h81;
    req_last = 4'b1110;
    req_valid = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (rdy_e == '0 && n < 200);
    chk("rst_first_ready", rdy_e, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_busy && n < 200);
    chk("rst_reached_busy", tx_busy, 1);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("rst_cycle_no_ready", rdy_e, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_outputs", {rdy_e, en_e, data_e, gid_e, act_e, err_e}, 0);
    chk("rst_mid_outputs_odd", {rdy_o, en_o, data_o, gid_o, act_o, err_o}, 0);
    chk("rst_mid_outputs_nopar", {rdy_n, en_n, data_n, gid_n, act_n, err_n}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;
    exp_err = 1'b0;
    send_vec(4'b1010, 8'h90, 1, 9'h191);
    send_vec(4'b1000, 8'hA0, 3, 9'h0A3);

    // Round robin with all requesters held valid.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'hE0 + 8'(i);
    req_last = '1;
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      seen = 1'b0;
      do begin @(negedge clk); n++; if (tx_busy) seen = 1'b1; end while (rdy_e == '0 && n < 200);
      chk("rr_order", rdy_e, oh(g % N));
      if (g > 0) chk("rr_busy_between", seen, 1);
      @(posedge clk);
    end
    #1 req_valid = '0;
    n = 0;
    while (act_e && n < 200) begin @(negedge clk); n++; end
    chk("rr_done", act_e, 0);

    // Randomized traffic against the arbitration model.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    ptr_m = 0; cur_m = 0; locked_m = 1'b0;
    pkts = 0; tot_bytes = 0; frames_seen = 0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (en_e) begin
        frames_seen++;
        chk("rnd_enable_not_busy", tx_busy, 0);
        chk("rnd_frame_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          f = expq.pop_front();
          chk("rnd_tx_data", data_e, f);
          chk("rnd_tx_data_odd", data_o, f ^ 9'h100);
          chk("rnd_tx_data_nopar", data_n, f[7:0]);
        end
      end
      acc = rdy_e;
      if (rdy_e != '0) begin
        w = -1;
        if (locked_m) begin
          if (req_valid[cur_m]) w = cur_m;
        end else begin
          for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[(ptr_m + k) % N]) w = (ptr_m + k) % N;
        end
        chk("rnd_grant", rdy_e, (w >= 0) ? oh(w) : '0);
        chk("rnd_ready_tx_idle", {tx_busy, en_e, dly != 0}, 0);
        if (w >= 0) begin
          b = req_data[w*DW +: DW];
          expq.push_back(even_frame(b));
          cur_m = w;
          locked_m = !req_last[w];
          if (req_last[w]) ptr_m = (w + 1) % N;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          rem[i]--;
          if (rem[i] == 0) begin
            req_valid[i] = 1'b0;
          end else begin
            req_data[i*DW +: DW] = 8'($urandom);
            req_last[i] = (rem[i] == 1);
          end
        end else if (!req_valid[i] && pkts < NPKT && $urandom_range(0, 3) == 0) begin
          rem[i] = $urandom_range(1, 3);
          pkts++;
          tot_bytes += rem[i];
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = 8'($urandom);
          req_last[i] = (rem[i] == 1);
        end
      end
      if (pkts == NPKT && req_valid == '0 && expq.size() == 0 && !act_e) break;
    end
    chk("rnd_requests_done", req_valid, 0);
    chk("rnd_queue_empty", expq.size(), 0);
    chk("rnd_frame_count", frames_seen, tot_bytes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
